// File: rtl/hero_write_rx_pkg.sv
// Shared types for the hero write bus and its receive-side beat buffer.
package hero_write_rx_pkg;

  localparam int unsigned HERO_WIDTH         = 36;
  localparam int unsigned HERO_RX_MAX_BEATS  = 8;
  localparam int unsigned HERO_RX_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    DONE  = 2'd2
  } CYCLE_TYPE_E;

  typedef struct packed {
    logic [3:0] id;
    logic       posted;
  } sub_def_t;

  typedef struct packed {
    CYCLE_TYPE_E           cycle_type;
    logic [HERO_WIDTH-1:0] wdat;
    sub_def_t              another_type_reference;
    logic                  clk_en;
  } hero_write_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BURST,
    RX_DROP
  } rx_state_e;

  typedef struct packed {
    logic [HERO_WIDTH-1:0] data;
    sub_def_t              sub;
    logic                  last;
    logic                  err;
  } rx_beat_t;

endpackage

// File: rtl/hero_rx_fifo.sv
// Synchronous beat FIFO with a registered head; push and pop may coincide at any fill level.
module hero_rx_fifo
  import hero_write_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  rx_beat_t         push_data,
  input  logic             pop,
  output logic             out_valid,
  output rx_beat_t         out_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  rx_beat_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && out_valid;
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rd_next = rd_ptr + PTR_W'(1);
  assign count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // The head register is fed straight from push_data whenever the pushed beat becomes the new head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_next;
      end
      count     <= count_d;
      out_valid <= (count_d != '0);
      if (do_push && ((count == '0) || (do_pop && (count == CNT_W'(1))))) begin
        out_data <= push_data;
      end else if (do_pop && (count > CNT_W'(1))) begin
        out_data <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/hero_write_rx.sv
// Hero write bus receiver: frames VALID..DONE writes into a buffered beat stream with
// per-transaction admission, drop accounting and sticky error flags.
module hero_write_rx #(
  parameter int unsigned HERO_WIDTH = hero_write_rx_pkg::HERO_WIDTH,
  parameter int unsigned MAX_BEATS  = hero_write_rx_pkg::HERO_RX_MAX_BEATS,
  parameter int unsigned FIFO_DEPTH = hero_write_rx_pkg::HERO_RX_FIFO_DEPTH
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [$bits(hero_write_rx_pkg::hero_write_t)-1:0]   i_hero_write,
  output logic                                                o_beat_valid,
  input  logic                                                i_beat_ready,
  output logic [HERO_WIDTH-1:0]                               o_beat_data,
  output logic [$bits(hero_write_rx_pkg::sub_def_t)-1:0]      o_beat_sub,
  output logic                                                o_beat_last,
  output logic                                                o_beat_err,
  output logic [15:0]                                         o_txn_cnt,
  output logic [15:0]                                         o_drop_cnt,
  output logic                                                o_overflow,
  output logic                                                o_proto_err,
  input  logic                                                i_clr_err
);

  import hero_write_rx_pkg::hero_write_t;
  import hero_write_rx_pkg::rx_beat_t;
  import hero_write_rx_pkg::rx_state_e;
  import hero_write_rx_pkg::RX_IDLE;
  import hero_write_rx_pkg::RX_BURST;
  import hero_write_rx_pkg::RX_DROP;
  import hero_write_rx_pkg::VALID;
  import hero_write_rx_pkg::DONE;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(MAX_BEATS);

  hero_write_t      hw_q;
  rx_state_e        state_q;
  rx_state_e        state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [CNT_W-1:0] fifo_count;
  rx_beat_t         fifo_out;
  rx_beat_t         push_beat_c;
  logic             push_c;
  logic             beat_c;
  logic             is_done_c;
  logic             admit_c;
  logic             txn_inc_c;
  logic             drop_inc_c;
  logic             proto_set_c;

  assign beat_c    = hw_q.clk_en && ((hw_q.cycle_type == VALID) || (hw_q.cycle_type == DONE));
  assign is_done_c = (hw_q.cycle_type == DONE);
  // Admission sees only registered occupancy, so a whole max-length burst always fits.
  assign admit_c   = (fifo_count <= CNT_W'(FIFO_DEPTH - MAX_BEATS));

  always_ff @(posedge clk) begin
    if (rst) begin
      hw_q    <= '0;
      state_q <= RX_IDLE;
      idx_q   <= '0;
    end else begin
      hw_q    <= hero_write_t'(i_hero_write);
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    push_c           = 1'b0;
    push_beat_c      = '0;
    push_beat_c.data = hw_q.wdat;
    push_beat_c.sub  = hw_q.another_type_reference;
    txn_inc_c        = 1'b0;
    drop_inc_c       = 1'b0;
    proto_set_c      = 1'b0;
    if (beat_c) begin
      unique case (state_q)
        RX_IDLE: begin
          if (admit_c) begin
            push_c = 1'b1;
            if (is_done_c) begin
              push_beat_c.last = 1'b1;
              txn_inc_c        = 1'b1;
            end else begin
              state_d = RX_BURST;
              idx_d   = IDX_W'(1);
            end
          end else begin
            drop_inc_c = 1'b1;
            if (!is_done_c) begin
              state_d = RX_DROP;
            end
          end
        end
        RX_BURST: begin
          push_c = 1'b1;
          if (is_done_c) begin
            push_beat_c.last = 1'b1;
            txn_inc_c        = 1'b1;
            state_d          = RX_IDLE;
            idx_d            = '0;
          end else if (idx_q == IDX_W'(MAX_BEATS - 1)) begin
            push_beat_c.last = 1'b1;
            push_beat_c.err  = 1'b1;
            proto_set_c      = 1'b1;
            txn_inc_c        = 1'b1;
            state_d          = RX_DROP;
            idx_d            = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        RX_DROP: begin
          if (is_done_c) begin
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Status counters and sticky flags; a set event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_txn_cnt   <= '0;
      o_drop_cnt  <= '0;
      o_overflow  <= 1'b0;
      o_proto_err <= 1'b0;
    end else begin
      if (txn_inc_c) begin
        o_txn_cnt <= o_txn_cnt + 16'd1;
      end
      if (drop_inc_c) begin
        o_overflow <= 1'b1;
        if (i_clr_err) begin
          o_drop_cnt <= 16'd1;
        end else if (o_drop_cnt != 16'hFFFF) begin
          o_drop_cnt <= o_drop_cnt + 16'd1;
        end
      end else if (i_clr_err) begin
        o_overflow <= 1'b0;
        o_drop_cnt <= '0;
      end
      if (proto_set_c) begin
        o_proto_err <= 1'b1;
      end else if (i_clr_err) begin
        o_proto_err <= 1'b0;
      end
    end
  end

  hero_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_beat_c),
    .pop       (i_beat_ready),
    .out_valid (o_beat_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign o_beat_data = fifo_out.data;
  assign o_beat_sub  = fifo_out.sub;
  assign o_beat_last = fifo_out.last;
  assign o_beat_err  = fifo_out.err;

endmodule
